// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, writable imem and DEPTH-entry prefetch FIFO with valid/ready delivery and redirect flush
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int IMEM_WORDS = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            redirect,
  input  logic [XLEN-1:0]                 redirect_target,
  input  logic                            inst_ready,
  output logic                            inst_valid,
  output logic [XLEN-1:0]                 inst,
  output logic [XLEN-1:0]                 inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  input  logic                            imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0]   imem_waddr,
  input  logic [XLEN-1:0]                 imem_wdata
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(IMEM_WORDS);
  typedef enum logic [1:0] {RESET, RUN, FLUSH} state_t;
  state_t state;
  logic [XLEN-1:0] mem [IMEM_WORDS];
  logic [XLEN-1:0] q_inst [DEPTH];
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] fetch_pc, imem_rd;
  logic [XLEN-3:0] widx;
  logic pop, push;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    widx = fetch_pc[XLEN-1:2];
    imem_rd = widx < (XLEN-2)'(IMEM_WORDS) ? mem[widx[AW-1:0]] : '0;
    inst_valid = state == RUN && cnt != '0;
    inst = q_inst[head];
    inst_pc = q_pc[head];
    count = cnt;
    pop = inst_valid && inst_ready && !redirect;
    push = !redirect && (cnt < CW'(DEPTH) || pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET;
      head <= '0;
      tail <= '0;
      cnt <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      state <= FLUSH;
      head <= '0;
      tail <= '0;
      cnt <= '0;
      fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
    end else begin
      state <= RUN;
      if (push) begin
        tail <= nxt(tail);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (pop) head <= nxt(head);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  // imem and FIFO payload carry no reset; only pointers/count qualify them
  always_ff @(posedge clk) begin
    if (imem_we && 32'(imem_waddr) < IMEM_WORDS) mem[imem_waddr] <= imem_wdata;
    if (push) begin
      q_inst[tail] <= imem_rd;
      q_pc[tail] <= fetch_pc;
    end
  end
endmodule
